// File: rtl/xc_rf_2.sv
// Parametrised GPR file: NREAD combinational read ports, 1-cycle single or paired write, optional bypass,
// and a clear sweep that zeroes one entry per cycle after reset or on request.
module xc_rf_2 #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [NREAD*AW-1:0]   rs_addr,
  output logic [NREAD*XLEN-1:0] rs_rdata,
  input  logic                  rd_wen,
  input  logic                  rd_wide,
  input  logic [AW-1:0]         rd_addr,
  input  logic [XLEN-1:0]       rd_wdata,
  input  logic [XLEN-1:0]       rd_wdata_hi,
  input  logic                  clear_req,
  output logic                  clear_busy
);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  localparam logic [AW-1:0] ONE  = AW'(1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            busy_q, busy_d;
  logic [XLEN-1:0] gpr_q [DEPTH];
  logic [XLEN-1:0] gpr_d [DEPTH];

  logic [AW-1:0]   wr_lo;
  logic [AW-1:0]   wr_hi;
  logic            wr_en_lo;
  logic            wr_en_hi;

  assign clear_busy = busy_q;

  // A paired write targets the even/odd pair; entry 0 is never a write target when hardwired.
  assign wr_lo    = rd_wide ? (rd_addr & ~ONE) : rd_addr;
  assign wr_hi    = rd_addr | ONE;
  assign wr_en_lo = rd_wen && !busy_q && !((ZERO_REG != 0) && (wr_lo == '0));
  assign wr_en_hi = rd_wen && rd_wide && !busy_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_CLEAR: begin
        ptr_d = ptr_q + ONE;
        if (ptr_q == LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    gpr_d = gpr_q;
    if (busy_q) begin
      gpr_d[ptr_q] = '0;
    end else begin
      if (wr_en_lo) gpr_d[wr_lo] = rd_wdata;
      if (wr_en_hi) gpr_d[wr_hi] = rd_wdata_hi;
    end
  end

  // Storage is not reset; the sweep brings every entry to a known value.
  always_ff @(posedge clock) begin
    gpr_q <= gpr_d;
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rdat;

    assign ra = rs_addr[g*AW +: AW];

    always_comb begin
      rdat = gpr_q[ra];
      if (BYPASS != 0) begin
        if (wr_en_lo && (ra == wr_lo)) rdat = rd_wdata;
        if (wr_en_hi && (ra == wr_hi)) rdat = rd_wdata_hi;
      end
      if (((ZERO_REG != 0) && (ra == '0)) || busy_q) rdat = '0;
    end

    assign rs_rdata[g*XLEN +: XLEN] = rdat;
  end

endmodule

// File: tb/tb_xc_rf_2.sv
// Directed bench for xc_rf_2: default instance, a 4-port bypass instance and a 64-bit/16-entry instance.
module tb_xc_rf_2;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  // Instance A: defaults
  logic [14:0]  a_rs_addr;
  logic [95:0]  a_rs_rdata;
  logic         a_wen, a_wide, a_creq, a_busy;
  logic [4:0]   a_addr;
  logic [31:0]  a_wd, a_wdh;
  // Instance B: NREAD=4, BYPASS=1
  logic [19:0]  b_rs_addr;
  logic [127:0] b_rs_rdata;
  logic         b_wen, b_wide, b_creq, b_busy;
  logic [4:0]   b_addr;
  logic [31:0]  b_wd, b_wdh;
  // Instance C: XLEN=64, DEPTH=16
  logic [11:0]  c_rs_addr;
  logic [191:0] c_rs_rdata;
  logic         c_wen, c_wide, c_creq, c_busy;
  logic [3:0]   c_addr;
  logic [63:0]  c_wd, c_wdh;

  xc_rf_2 u_a (
    .clock(clock), .resetn(resetn), .rs_addr(a_rs_addr), .rs_rdata(a_rs_rdata),
    .rd_wen(a_wen), .rd_wide(a_wide), .rd_addr(a_addr), .rd_wdata(a_wd),
    .rd_wdata_hi(a_wdh), .clear_req(a_creq), .clear_busy(a_busy)
  );

  xc_rf_2 #(.NREAD(4), .BYPASS(1)) u_b (
    .clock(clock), .resetn(resetn), .rs_addr(b_rs_addr), .rs_rdata(b_rs_rdata),
    .rd_wen(b_wen), .rd_wide(b_wide), .rd_addr(b_addr), .rd_wdata(b_wd),
    .rd_wdata_hi(b_wdh), .clear_req(b_creq), .clear_busy(b_busy)
  );

  xc_rf_2 #(.XLEN(64), .DEPTH(16)) u_c (
    .clock(clock), .resetn(resetn), .rs_addr(c_rs_addr), .rs_rdata(c_rs_rdata),
    .rd_wen(c_wen), .rd_wide(c_wide), .rd_addr(c_addr), .rd_wdata(c_wd),
    .rd_wdata_hi(c_wdh), .clear_req(c_creq), .clear_busy(c_busy)
  );

  typedef struct {
    logic        wen;
    logic        wide;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] wdh;
    logic [4:0]  ra0, ra1, ra2;
    logic [31:0] e0, e1, e2;
  } vec_t;

  vec_t vecs [9];
  int   total = 0;
  int   bad   = 0;
  int   ca, cc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] a_rd(input int k);
    return a_rs_rdata[k*32 +: 32];
  endfunction

  function automatic logic [31:0] b_rd(input int k);
    return b_rs_rdata[k*32 +: 32];
  endfunction

  function automatic logic [63:0] c_rd(input int k);
    return c_rs_rdata[k*64 +: 64];
  endfunction

  task automatic set_a_rs(input logic [4:0] p0, input logic [4:0] p1, input logic [4:0] p2);
    a_rs_addr = {p2, p1, p0};
  endtask

  task automatic set_b_rs(input logic [4:0] p0, input logic [4:0] p1,
                          input logic [4:0] p2, input logic [4:0] p3);
    b_rs_addr = {p3, p2, p1, p0};
  endtask

  task automatic idle_all();
    a_wen = 1'b0; a_wide = 1'b0; a_addr = '0; a_wd = '0; a_wdh = '0; a_creq = 1'b0;
    b_wen = 1'b0; b_wide = 1'b0; b_addr = '0; b_wd = '0; b_wdh = '0; b_creq = 1'b0;
    c_wen = 1'b0; c_wide = 1'b0; c_addr = '0; c_wd = '0; c_wdh = '0; c_creq = 1'b0;
  endtask

  // Called at a falling edge; counts sampled busy cycles of A and C until both are idle.
  task automatic sweep_count(output int na, output int nc);
    na = 0;
    nc = 0;
    for (int i = 0; i < 200; i++) begin
      set_a_rs(5'($urandom_range(31)), 5'($urandom_range(31)), 5'($urandom_range(31)));
      #1;
      if (!a_busy && !c_busy) break;
      if (a_busy) begin
        na++;
        check("sweep_rd_a", a_rd(i % 3), 32'h0);
      end
      if (c_busy) nc++;
      @(negedge clock);
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 5'd5,  32'hDEADBEEF, 32'h0,        5'd5,  5'd5, 5'd5, 32'h0,        32'h0,        32'h0};
    vecs[1] = '{1'b1, 1'b0, 5'd0,  32'h00001234, 32'h0,        5'd5,  5'd0, 5'd5, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b1, 5'd7,  32'hAAAA0001, 32'hBBBB0002, 5'd0,  5'd6, 5'd7, 32'h0,        32'h0,        32'h0};
    vecs[3] = '{1'b1, 1'b1, 5'd0,  32'h11111111, 32'h22222222, 5'd6,  5'd7, 5'd0, 32'hAAAA0001, 32'hBBBB0002, 32'h0};
    vecs[4] = '{1'b0, 1'b1, 5'd5,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  5'd1, 5'd5, 32'h0,        32'h22222222, 32'hDEADBEEF};
    vecs[5] = '{1'b1, 1'b0, 5'd9,  32'h00000055, 32'h0,        5'd9,  5'd9, 5'd1, 32'h0,        32'h0,        32'h22222222};
    vecs[6] = '{1'b1, 1'b0, 5'd31, 32'h31313131, 32'h0,        5'd9,  5'd4, 5'd5, 32'h00000055, 32'h0,        32'hDEADBEEF};
    vecs[7] = '{1'b1, 1'b0, 5'd6,  32'h00000066, 32'h0,        5'd31, 5'd5, 5'd6, 32'h31313131, 32'hDEADBEEF, 32'hAAAA0001};
    vecs[8] = '{1'b0, 1'b0, 5'd0,  32'h0,        32'h0,        5'd6,  5'd7, 5'd0, 32'h00000066, 32'hBBBB0002, 32'h0};

    idle_all();
    set_a_rs(5'd5, 5'd6, 5'd7);
    set_b_rs(5'd0, 5'd0, 5'd0, 5'd0);
    c_rs_addr = '0;
    resetn = 1'b0;

    // Reset state: busy and reads masked to zero
    repeat (3) @(negedge clock);
    #1;
    check("rst_busy_a", 64'(a_busy), 64'd1);
    check("rst_busy_c", 64'(c_busy), 64'd1);
    check("rst_rd_a0", a_rd(0), 32'h0);
    check("rst_rd_a2", a_rd(2), 32'h0);
    @(negedge clock);
    resetn = 1'b1;
    sweep_count(ca, cc);
    check("busy_len_a", 64'(ca), 64'd32);
    check("busy_len_c", 64'(cc), 64'd16);

    for (int a = 0; a < 32; a++) begin
      set_a_rs(5'(a), 5'(a), 5'(a));
      #1;
      check($sformatf("post_clr_r%0d_p0", a), a_rd(0), 32'h0);
      check($sformatf("post_clr_r%0d_p1", a), a_rd(1), 32'h0);
      check($sformatf("post_clr_r%0d_p2", a), a_rd(2), 32'h0);
      @(negedge clock);
    end

    // Table of writes/reads on A; expectations are pre-edge (no bypass)
    for (int v = 0; v < 9; v++) begin
      @(negedge clock);
      a_wen = vecs[v].wen; a_wide = vecs[v].wide; a_addr = vecs[v].wa;
      a_wd = vecs[v].wd; a_wdh = vecs[v].wdh;
      set_a_rs(vecs[v].ra0, vecs[v].ra1, vecs[v].ra2);
      #1;
      check($sformatf("vec%0d_p0", v), a_rd(0), vecs[v].e0);
      check($sformatf("vec%0d_p1", v), a_rd(1), vecs[v].e1);
      check($sformatf("vec%0d_p2", v), a_rd(2), vecs[v].e2);
    end
    @(negedge clock);
    idle_all();

    // Bypass instance B
    b_wen = 1'b1; b_addr = 5'd9; b_wd = 32'h55;
    set_b_rs(5'd3, 5'd0, 5'd9, 5'd9);
    #1;
    check("byp_p2_same", b_rd(2), 32'h55);
    check("byp_p3_same", b_rd(3), 32'h55);
    check("byp_p0_other", b_rd(0), 32'h0);
    @(negedge clock);
    b_wen = 1'b0;
    #1;
    check("byp_p2_next", b_rd(2), 32'h55);
    @(negedge clock);
    b_wen = 1'b1; b_wide = 1'b1; b_addr = 5'd9; b_wd = 32'hA8; b_wdh = 32'hA9;
    set_b_rs(5'd8, 5'd9, 5'd0, 5'd2);
    #1;
    check("byp_wide_lo", b_rd(0), 32'hA8);
    check("byp_wide_hi", b_rd(1), 32'hA9);
    check("byp_wide_r2", b_rd(3), 32'h0);
    @(negedge clock);
    b_addr = 5'd1; b_wd = 32'h77; b_wdh = 32'h78;
    set_b_rs(5'd0, 5'd1, 5'd8, 5'd9);
    #1;
    check("byp_zero_r0", b_rd(0), 32'h0);
    check("byp_pair0_hi", b_rd(1), 32'h78);
    check("byp_stored_lo", b_rd(2), 32'hA8);
    @(negedge clock);
    idle_all();
    set_b_rs(5'd8, 5'd9, 5'd1, 5'd0);
    #1;
    check("byp_after_r8", b_rd(0), 32'hA8);
    check("byp_after_r9", b_rd(1), 32'hA9);
    check("byp_after_r1", b_rd(2), 32'h78);
    check("byp_after_r0", b_rd(3), 32'h0);

    // 64-bit / 16-entry instance C
    @(negedge clock);
    c_wen = 1'b1; c_addr = 4'd15; c_wd = 64'h0123456789ABCDEF;
    @(negedge clock);
    c_wide = 1'b1; c_addr = 4'd2; c_wd = 64'h1111_0000_0000_1111; c_wdh = 64'h2222_0000_0000_2222;
    @(negedge clock);
    idle_all();
    c_rs_addr = {4'd15, 4'd3, 4'd2};
    #1;
    check("c64_r2", c_rd(0), 64'h1111_0000_0000_1111);
    check("c64_r3", c_rd(1), 64'h2222_0000_0000_2222);
    check("c64_r15", c_rd(2), 64'h0123456789ABCDEF);

    // Fill A, then request a clear; writes and a second request during the sweep have no effect
    @(negedge clock);
    for (int i = 1; i < 32; i++) begin
      a_wen = 1'b1; a_addr = 5'(i); a_wd = 32'hC0DE0000 | 32'(i);
      @(negedge clock);
    end
    a_wen = 1'b0;
    set_a_rs(5'd1, 5'd17, 5'd31);
    #1;
    check("fill_r1", a_rd(0), 32'hC0DE0001);
    check("fill_r17", a_rd(1), 32'hC0DE0011);
    check("fill_r31", a_rd(2), 32'hC0DE001F);
    @(negedge clock);
    a_creq = 1'b1;
    #1;
    check("clr_req_cycle_busy", 64'(a_busy), 64'd0);
    @(negedge clock);
    a_creq = 1'b0;
    ca = 0;
    for (int i = 0; i < 200; i++) begin
      set_a_rs(5'd3, 5'(i % 32), 5'd17);
      #1;
      if (!a_busy) break;
      ca++;
      check("clr_busy_rd_r3", a_rd(0), 32'h0);
      a_wen = (i == 3); a_addr = 5'd3; a_wd = 32'h00000BAD;
      a_creq = (i == 20);
      @(negedge clock);
    end
    idle_all();
    check("clr_busy_len", 64'(ca), 64'd32);
    for (int a = 0; a < 32; a++) begin
      set_a_rs(5'(a), 5'(a), 5'(a));
      #1;
      check($sformatf("clr_after_r%0d", a), a_rd(a % 3), 32'h0);
      @(negedge clock);
    end

    // Asynchronous reset, then a second reset part-way through the sweep
    #1;
    resetn = 1'b0;
    #1;
    check("async_rst_busy_a", 64'(a_busy), 64'd1);
    check("async_rst_busy_c", 64'(c_busy), 64'd1);
    @(negedge clock);
    resetn = 1'b1;
    repeat (10) @(negedge clock);
    #1;
    check("mid_sweep_busy", 64'(a_busy), 64'd1);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    sweep_count(ca, cc);
    check("rst_restart_len_a", 64'(ca), 64'd32);
    check("rst_restart_len_c", 64'(cc), 64'd16);
    set_a_rs(5'd0, 5'd1, 5'd31);
    #1;
    check("restart_r1", a_rd(1), 32'h0);
    check("restart_r31", a_rd(2), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xc_rf_2.md
Name: xc_rf_2

Overview:
- Parametrised successor to the 3-read/1-write GPR file.
- Configurable read-port count, word width and depth.
- Adds an optional write-to-read bypass and a paired "wide" write that updates an even/odd register pair in one cycle, for multi-precision results.
- Adds a hardware clear sequencer that sweeps every entry to zero after reset or on request.
- Sits in the decode/writeback stage of the core.

Parameters:
- XLEN, 32, data word width in bits.
- DEPTH, 32, number of registers; power of two, >= 2.
- NREAD, 3, number of read ports, 1..8.
- ZERO_REG, 1, when 1, entry 0 always reads 0 and ignores writes.
- BYPASS, 0, when 1, a same-cycle write to a read address is forwarded to that read port.
- AW, $clog2(DEPTH), address width (derived; not overridden).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- resetn  input  1  asynchronous active-low reset.
- rs_addr  input  NREAD*AW  read addresses; port k uses bits [k*AW +: AW].
- rs_rdata  output  NREAD*XLEN  read data; port k uses bits [k*XLEN +: XLEN].
- rd_wen  input  1  write enable.
- rd_wide  input  1  when 1 with rd_wen, perform a paired write.
- rd_addr  input  AW  write address.
- rd_wdata  input  XLEN  write data (low half for wide writes).
- rd_wdata_hi  input  XLEN  high-half data, used only when rd_wide=1.
- clear_req  input  1  single-cycle pulse requesting a full clear.
- clear_busy  output  1  high while the clear sweep is running.

Behaviour:
- Reads are combinational from storage: rs_rdata[k] = gpr[rs_addr[k]].
- If ZERO_REG=1 and rs_addr[k]==0, rs_rdata[k]=0.
- While clear_busy=1, every rs_rdata port reads 0 regardless of address.
- Normal write: rd_wen=1, rd_wide=0 -> gpr[rd_addr] <= rd_wdata at the next edge. Write latency is 1 cycle.
- Wide write: rd_wen=1, rd_wide=1 -> at the same edge:
  - gpr[{rd_addr[AW-1:1],1'b0}] <= rd_wdata
  - gpr[{rd_addr[AW-1:1],1'b1}] <= rd_wdata_hi
  - rd_addr[0] is ignored.
- ZERO_REG=1:
  - Writes to entry 0 are dropped, including the low half of a wide write to pair 0.
  - The high half still writes entry 1.
- rd_wide with rd_wen=0 has no effect.
- Bypass, BYPASS=1, clear_busy=0, rd_wen=1:
  - Any read port whose address matches a written entry returns the data being written this cycle (rd_wdata or rd_wdata_hi as appropriate), combinationally.
  - The ZERO_REG rule takes precedence: a read of entry 0 still returns 0.
- BYPASS=0: reads return the pre-write value in the write cycle and the new value from the next cycle.
- Clear sequencer FSM, states IDLE and CLEAR, AW-bit pointer ptr:
  - resetn=0 (async): state=CLEAR, ptr=0, clear_busy=1. Storage contents are not reset directly.
  - CLEAR: each cycle gpr[ptr] <= 0 and ptr <= ptr+1. When ptr==DEPTH-1, that entry is cleared and state -> IDLE.
  - clear_busy is high for exactly DEPTH cycles after resetn rises, then 0.
  - IDLE: clear_req=1 -> CLEAR with ptr=0; clear_busy rises the next cycle.
  - clear_req while in CLEAR is ignored; the sweep does not restart.
  - Writes (rd_wen) while clear_busy=1 are dropped entirely.
  - resetn asserted mid-sweep returns to CLEAR with ptr=0 and the sweep restarts from entry 0.
- No X may propagate to rs_rdata once clear_busy has fallen.

Test Plan:
- Reset release, default params -> clear_busy=1 for exactly 32 cycles, then 0. All 3 ports read 0 during and after the sweep for every address.
- After clear, write 0xDEADBEEF to r5, then read r5 on ports 0..2 -> 0xDEADBEEF on the following cycle. Write 0x1234 to r0 -> r0 still reads 0.
- Wide write rd_addr=7, rd_wdata=0xAAAA0001, rd_wdata_hi=0xBBBB0002 -> r6=0xAAAA0001, r7=0xBBBB0002. Wide write to rd_addr=0 -> r0 stays 0, r1=rd_wdata_hi.
- BYPASS=1, NREAD=4: write 0x55 to r9 while port 2 reads r9 -> port 2 returns 0x55 in the same cycle. Repeat with BYPASS=0 -> old value that cycle, 0x55 the next.
- Mid-operation: fill r1..r31 with nonzero values, pulse clear_req -> 32 busy cycles. A write to r3 issued during busy is dropped, a second clear_req during the sweep is ignored, and all entries read 0 afterward.
- Assert resetn=0 at sweep cycle 10, release -> sweep restarts from ptr 0, with a full DEPTH busy cycles; XLEN=64, DEPTH=16 variant -> busy lasts 16 cycles.
